dmem_responder: RTL and testbench

Data-memory responder for the Cardinal processor's Dmem port. It sits at the memory end of the Mem_Addr/Data_Out/Data_In/DmemEn/DmemWrEn interface and services one load or one store per cycle, returning registered read data. Memory is a 256x64 single-port array that is zeroed by a hardware clear sequence after reset. Stores are posted into a small write buffer that drains to the array on cycles with no read, and loads bypass from that buffer.

---
 rtl/dmem_responder_if.sv | 41 ++++
 rtl/dmem_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Bundle of the processor Dmem port as seen by the data-memory responder.
//   master : processor side   (drives Mem_Addr, Wr_Data, DmemEn, DmemWrEn)
//   slave  : responder side   (drives Rd_Data, Init_Done, Wb_Count, Wb_Ovf)
// Signals
//   Mem_Addr   ADDR_W       word address
//   Wr_Data    DATA_W       store data (processor Data_Out)
//   DmemEn     1            request valid
//   DmemWrEn   1            1 = store, 0 = load (qualified by DmemEn)
//   Rd_Data    DATA_W       registered load data (processor Data_In)
//   Init_Done  1            array clear sequence finished
//   Wb_Count   CNT_W        write-buffer occupancy, 0..WB_DEPTH
//   Wb_Ovf     1            sticky write-buffer overflow
// -----------------------------------------------------------------------------
interface dmem_responder_if #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 8,
    parameter int WB_DEPTH = 4
) ();
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Wr_Data;
    logic              DmemEn;
    logic              DmemWrEn;
    logic [DATA_W-1:0] Rd_Data;
    logic              Init_Done;
    logic [CNT_W-1:0]  Wb_Count;
    logic              Wb_Ovf;

    modport master (
        output Mem_Addr, Wr_Data, DmemEn, DmemWrEn,
        input  Rd_Data, Init_Done, Wb_Count, Wb_Ovf
    );

    modport slave (
        input  Mem_Addr, Wr_Data, DmemEn, DmemWrEn,
        output Rd_Data, Init_Done, Wb_Count, Wb_Ovf
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the Cardinal Dmem port. Services one load or one
// store per cycle against a DEPTH x DATA_W single-port array that is zeroed by
// a clear sequence after reset. Stores are posted into a WB_DEPTH-entry FIFO
// that drains to the array on cycles without a load; loads bypass from the
// FIFO (newest matching entry wins).
// Ports
//   Clock  in   rising-edge clock
//   Reset  in   asynchronous active-low reset
//   bus    slave modport of dmem_responder_if (request in, status/data out)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 256,
    parameter int WB_DEPTH = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    dmem_responder_if.slave    bus
);
    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

    // ---------------------------------------------------------------- state
    state_t state_reg;
    state_t state_next;
    logic   clear_we;
    logic   ready;

    logic [ADDR_W-1:0] clear_ptr_reg;

    // --------------------------------------------------------- write buffer
    logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
    logic [DATA_W-1:0] wb_data [WB_DEPTH];
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              ovf_reg;

    logic load;
    logic store;
    logic wb_empty;
    logic wb_full;
    logic push;
    logic pop;
    logic ovf_set;

    // ------------------------------------------------------------- bypass
    logic [PTR_W-1:0]    age_idx [WB_DEPTH];
    logic [WB_DEPTH-1:0] age_hit;
    logic                byp_hit;
    logic [DATA_W-1:0]   byp_data;

    // -------------------------------------------------------------- array
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // ---------------------------------------------------------- read path
    logic              rd_from_mem_reg;
    logic [DATA_W-1:0] rd_hold_reg;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(WB_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // =====================================================================
    // FSM: state register / next state / outputs
    // =====================================================================
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= CLEAR;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CLEAR: begin
                // Last array word is written this cycle.
                if (clear_ptr_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = READY;
                end
            end
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        clear_we = 1'b0;
        ready    = 1'b0;
        case (state_reg)
            CLEAR:   clear_we = 1'b1;
            READY:   ready    = 1'b1;
            default: clear_we = 1'b1;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clear_ptr_reg <= '0;
        end else if (clear_we) begin
            clear_ptr_reg <= clear_ptr_reg + ADDR_W'(1);
        end
    end

    // =====================================================================
    // Request decode and write-buffer control
    // =====================================================================
    assign load     = bus.DmemEn & ~bus.DmemWrEn;
    assign store    = bus.DmemEn &  bus.DmemWrEn;
    assign wb_empty = (count_reg == '0);
    assign wb_full  = (count_reg == CNT_W'(WB_DEPTH));

    // A load owns the single array port, so draining only happens on
    // non-load cycles, and never while the clear sequence owns the port.
    assign pop     = ready & ~load & ~wb_empty;
    // A full buffer can still accept a store when the head leaves the same edge.
    assign push    = store & (~wb_full | pop);
    assign ovf_set = store & wb_full & ~pop;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
            if (ovf_set) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge Clock) begin
        if (push) begin
            wb_addr[tail_reg] <= bus.Mem_Addr;
            wb_data[tail_reg] <= bus.Wr_Data;
        end
    end

    // =====================================================================
    // Bypass: walk entries from oldest (age 0) to newest so the youngest
    // matching store is the one that survives.
    // =====================================================================
    genvar gi;
    generate
        for (gi = 0; gi < WB_DEPTH; gi++) begin : g_age
            logic [PTR_W:0] slot_sum;
            assign slot_sum = {1'b0, head_reg} + (PTR_W+1)'(gi);
            assign age_idx[gi] = (slot_sum >= (PTR_W+1)'(WB_DEPTH))
                               ? PTR_W'(slot_sum - (PTR_W+1)'(WB_DEPTH))
                               : PTR_W'(slot_sum);
            assign age_hit[gi] = (CNT_W'(gi) < count_reg) &&
                                 (wb_addr[age_idx[gi]] == bus.Mem_Addr);
        end
    endgenerate

    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (age_hit[k]) begin
                byp_hit  = 1'b1;
                byp_data = wb_data[age_idx[k]];
            end
        end
    end

    // =====================================================================
    // Array: one write (clear or drain) and a registered read per cycle.
    // A read and a write never land on the same cycle in READY because a
    // load suppresses draining.
    // =====================================================================
    assign mem_we    = clear_we | pop;
    assign mem_waddr = clear_we ? clear_ptr_reg : wb_addr[head_reg];
    assign mem_wdata = clear_we ? '0 : wb_data[head_reg];

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (load) begin
            mem_q <= mem[bus.Mem_Addr];
        end
    end

    // Read-source select. Bypass data (or zero during the clear) is latched
    // alongside the array read; both registers only move on a load, so the
    // output holds between loads.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd_from_mem_reg <= 1'b0;
            rd_hold_reg     <= '0;
        end else if (load) begin
            rd_from_mem_reg <= ready & ~byp_hit;
            rd_hold_reg     <= byp_hit ? byp_data : '0;
        end
    end

    // =====================================================================
    // Outputs
    // =====================================================================
    assign bus.Rd_Data   = rd_from_mem_reg ? mem_q : rd_hold_reg;
    assign bus.Init_Done = ready;
    assign bus.Wb_Count  = count_reg;
    assign bus.Wb_Ovf    = ovf_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. Load expectations go into a
// scoreboard queue when the load is driven and are popped when Rd_Data
// appears one edge later. A vector table covers READY-state traffic; hand
// sequences cover the clear phase, overflow and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 8;
    localparam int DEPTH    = 256;
    localparam int WB_DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WB_DEPTH(WB_DEPTH)) bus ();

    dmem_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WB_DEPTH(WB_DEPTH)
    ) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] exp_q [$];

    typedef struct {
        logic        en;
        logic        we;
        logic [7:0]  addr;
        logic [63:0] data;
        logic [63:0] exp_rd;   // Rd_Data expected after this row's edge
        logic [2:0]  exp_cnt;  // Wb_Count expected after this row's edge
    } vec_t;

    vec_t vecs [32];
    int   nvec;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request cycle; loads are scored through the queue.
    task automatic cycle(input logic en, input logic we, input logic [7:0] addr,
                         input logic [63:0] data, input logic [63:0] exp, input string name);
        logic [63:0] e;
        bus.DmemEn   = en;
        bus.DmemWrEn = we;
        bus.Mem_Addr = addr;
        bus.Wr_Data  = data;
        if (en && !we) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        cyc++;
        if (en && !we) begin
            e = exp_q.pop_front();
            check64(name, bus.Rd_Data, e);
            $display("load  addr=%h rd=%h exp=%h cnt=%0d", addr, bus.Rd_Data, e, bus.Wb_Count);
        end else if (en) begin
            $display("store addr=%h data=%h cnt=%0d ovf=%0b", addr, data, bus.Wb_Count, bus.Wb_Ovf);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 64'h0, 64'h0, "idle");
    endtask

    task automatic store(input logic [7:0] a, input logic [63:0] d);
        cycle(1'b1, 1'b1, a, d, 64'h0, "store");
    endtask

    task automatic load(input logic [7:0] a, input logic [63:0] e, input string name);
        cycle(1'b1, 1'b0, a, 64'h0, e, name);
    endtask

    task automatic do_reset(input string name);
        rst_n        = 1'b0;
        bus.DmemEn   = 1'b0;
        bus.DmemWrEn = 1'b0;
        bus.Mem_Addr = '0;
        bus.Wr_Data  = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check64({name, "_rst_init_done"}, 64'(bus.Init_Done), 64'd0);
        check64({name, "_rst_rd_data"},   bus.Rd_Data,        64'd0);
        check64({name, "_rst_wb_count"},  64'(bus.Wb_Count),  64'd0);
        check64({name, "_rst_wb_ovf"},    64'(bus.Wb_Ovf),    64'd0);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Idle until Init_Done, bounded; the rise must land on cycle 256.
    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (!bus.Init_Done && n < 400) begin
            idle();
            n++;
        end
        check64({name, "_init_done"},  64'(bus.Init_Done), 64'd1);
        check64({name, "_init_cycle"}, 64'(cyc),           64'd256);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ------------------------------------------------ vector table
        nvec = 0;
        vecs[nvec++] = '{1'b1, 1'b1, 8'h05, 64'h0123456789ABCDEF, 64'h0, 3'd1};
        vecs[nvec++] = '{1'b1, 1'b0, 8'h05, 64'h0, 64'h0123456789ABCDEF, 3'd1};
        vecs[nvec++] = '{1'b0, 1'b0, 8'h00, 64'h0, 64'h0123456789ABCDEF, 3'd0};
        vecs[nvec++] = '{1'b0, 1'b1, 8'h05, 64'hDEADDEADDEADDEAD, 64'h0123456789ABCDEF, 3'd0};
        vecs[nvec++] = '{1'b1, 1'b0, 8'h05, 64'h0, 64'h0123456789ABCDEF, 3'd0};
        vecs[nvec++] = '{1'b0, 1'b0, 8'h00, 64'h0, 64'h0123456789ABCDEF, 3'd0};
        for (int i = 0; i < 10; i++) begin
            vecs[nvec++] = '{1'b1, 1'b1, 8'h20, 64'h1000 + 64'(i),
                             (i == 0) ? 64'h0123456789ABCDEF : 64'h1000 + 64'(i - 1), 3'd1};
            vecs[nvec++] = '{1'b1, 1'b0, 8'h20, 64'h0, 64'h1000 + 64'(i), 3'd1};
        end
        vecs[nvec++] = '{1'b0, 1'b0, 8'h00, 64'h0, 64'h1009, 3'd0};
        vecs[nvec++] = '{1'b1, 1'b0, 8'h20, 64'h0, 64'h1009, 3'd0};
        vecs[nvec++] = '{1'b1, 1'b0, 8'h7F, 64'h0, 64'h0, 3'd0};

        // ------------------------------------------------ clear phase, zero reads
        do_reset("t1");
        load(8'h10, 64'h0, "t1_load_during_clear");
        wait_init("t1");
        load(8'h00, 64'h0, "t1_load_00");
        load(8'h7F, 64'h0, "t1_load_7f");
        load(8'hFF, 64'h0, "t1_load_ff");

        // ------------------------------------------------ READY traffic table
        for (int i = 0; i < nvec; i++) begin
            cycle(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp_rd,
                  $sformatf("vec%0d_rd", i));
            if (!(vecs[i].en && !vecs[i].we))
                check64($sformatf("vec%0d_hold", i), bus.Rd_Data, vecs[i].exp_rd);
            check64($sformatf("vec%0d_cnt", i), 64'(bus.Wb_Count), 64'(vecs[i].exp_cnt));
        end
        check64("vec_ovf", 64'(bus.Wb_Ovf), 64'd0);

        // ------------------------------------------------ same-address stores in CLEAR
        do_reset("t3");
        store(8'h03, 64'hAAAAAAAAAAAAAAAA);
        store(8'h03, 64'h5555555555555555);
        load(8'h03, 64'h5555555555555555, "t3_bypass_younger");
        check64("t3_cnt_two", 64'(bus.Wb_Count), 64'd2);
        wait_init("t3");
        idle();
        idle();
        check64("t3_cnt_drained", 64'(bus.Wb_Count), 64'd0);
        load(8'h03, 64'h5555555555555555, "t3_array_younger");

        // ------------------------------------------------ overflow in CLEAR
        do_reset("t4");
        for (int i = 0; i < 5; i++) begin
            store(8'(10 + i), 64'hB000000000000000 + 64'(i));
            check64($sformatf("t4_cnt%0d", i), 64'(bus.Wb_Count), (i < 4) ? 64'(i + 1) : 64'd4);
            check64($sformatf("t4_ovf%0d", i), 64'(bus.Wb_Ovf), (i == 4) ? 64'd1 : 64'd0);
        end
        wait_init("t4");
        repeat (4) idle();
        check64("t4_cnt_drained", 64'(bus.Wb_Count), 64'd0);
        for (int i = 0; i < 4; i++)
            load(8'(10 + i), 64'hB000000000000000 + 64'(i), $sformatf("t4_load%0d", 10 + i));
        load(8'd14, 64'h0, "t4_load_dropped");
        check64("t4_ovf_sticky", 64'(bus.Wb_Ovf), 64'd1);

        // ------------------------------------------------ async reset mid-clear
        do_reset("t5");
        for (int i = 0; i < 5; i++)
            store(8'(7 + i), 64'hC0C0C0C000000000 + 64'(i));
        load(8'h07, 64'hC0C0C0C000000000, "t5_bypass");
        check64("t5_ovf_before", 64'(bus.Wb_Ovf), 64'd1);
        while (cyc < 100) idle();
        rst_n = 1'b0;
        #1;
        check64("t5_async_init_done", 64'(bus.Init_Done), 64'd0);
        check64("t5_async_rd_data",   bus.Rd_Data,        64'd0);
        check64("t5_async_wb_count",  64'(bus.Wb_Count),  64'd0);
        check64("t5_async_wb_ovf",    64'(bus.Wb_Ovf),    64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        wait_init("t5_restart");
        repeat (4) idle();
        check64("t5_cnt_empty", 64'(bus.Wb_Count), 64'd0);
        load(8'h07, 64'h0, "t5_discarded_store");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
